// File: rtl/myocontrol_spi_slave.sv
// myocontrol_spi_slave
//   SPI slave endpoint for the motor-board side of the myocontrol link.
//   sck/mosi/ss_n are oversampled in the clk domain, 16-bit words are
//   deframed into a strobed receive stream, and a transmit word stream
//   (fetched by word index) is serialised onto miso in the same frame.
//   SPI mode 0 (CPOL=0, CPHA=0), MSB first.
//
// Optional feature macro: MYOCONTROL_SLAVE_CHECKSUM_EN
//   When defined, the last word of a nominal frame carries a 16-bit
//   wrap-around sum, generated on transmit and checked on receive.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   sck, mosi, ss_n     asynchronous SPI pins from the master
//   miso, miso_oe       slave data and pad output enable
//   tx_index, tx_word   word index request / application word for it
//   rx_word, rx_index   last received word and its index in the frame
//   rx_valid            one-cycle strobe for rx_word/rx_index
//   frame_start/done    one-cycle strobes on synced ss_n fall/rise
//   frame_error         qualified by frame_done
//
// state | meaning
// IDLE  | not selected, tx_index held at 0, miso pad tri-stated
// LOAD  | one cycle after ss_n fall: load word 0, clear counters
// SHIFT | bits shift in on sck rise, out on sck fall
// DONE  | one cycle after ss_n rise: frame_done with error status

module myocontrol_spi_slave #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAME_WORDS = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sck,
  input  logic                  mosi,
  input  logic                  ss_n,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [7:0]            tx_index,
  input  logic [DATA_WIDTH-1:0] tx_word,
  output logic [DATA_WIDTH-1:0] rx_word,
  output logic [7:0]            rx_index,
  output logic                  rx_valid,
  output logic                  frame_start,
  output logic                  frame_done,
  output logic                  frame_error
);

  localparam int              BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0]   BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [7:0]      NWORDS   = 8'(FRAME_WORDS);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t state_q, state_d;

  logic sck_s1, sck_s2, sck_d;
  logic ss_s1, ss_s2, ss_d;
  logic mosi_s1, mosi_s2;

  logic sck_rise, sck_fall, ss_rise, ss_fall;

  logic [BW-1:0]           bit_cnt;
  logic [7:0]              word_cnt;
  logic [DATA_WIDTH-2:0]   rx_shreg;
  logic [DATA_WIDTH-1:0]   rx_next;
  logic [DATA_WIDTH-1:0]   tx_shreg;
  logic                    overrun;
  logic                    err_q;

`ifdef MYOCONTROL_SLAVE_CHECKSUM_EN
  localparam logic [7:0]   LAST_WORD = 8'(FRAME_WORDS - 1);
  logic [DATA_WIDTH-1:0]   tx_sum;
  logic [DATA_WIDTH-1:0]   rx_sum;
  logic                    cksum_err;
`endif

  // Two-flop synchronizers plus one edge-detect register. ss_n idles high,
  // so its flops reset to 1 to avoid a phantom frame_start after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_d   <= 1'b0;
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
      ss_d    <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sck_s1  <= sck;
      sck_s2  <= sck_s1;
      sck_d   <= sck_s2;
      ss_s1   <= ss_n;
      ss_s2   <= ss_s1;
      ss_d    <= ss_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sck_rise = sck_s2 & ~sck_d;
  assign sck_fall = ~sck_s2 & sck_d;
  assign ss_fall  = ~ss_s2 & ss_d;
  assign ss_rise  = ss_s2 & ~ss_d;

  // mosi_s2 is aligned with sck_s2, so it is the bit present at the rise.
  assign rx_next = {rx_shreg, mosi_s2};
  assign miso    = tx_shreg[DATA_WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    miso_oe     = 1'b1;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    frame_error = 1'b0;
    case (state_q)
      IDLE: begin
        miso_oe = 1'b0;
        if (ss_fall) state_d = LOAD;
      end
      LOAD: begin
        frame_start = 1'b1;
        state_d     = SHIFT;
      end
      SHIFT: begin
        if (ss_rise) state_d = DONE;
      end
      DONE: begin
        frame_done  = 1'b1;
        frame_error = err_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_index <= '0;
      rx_word  <= '0;
      rx_index <= '0;
      rx_valid <= 1'b0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      rx_shreg <= '0;
      tx_shreg <= '0;
      overrun  <= 1'b0;
      err_q    <= 1'b0;
`ifdef MYOCONTROL_SLAVE_CHECKSUM_EN
      tx_sum    <= '0;
      rx_sum    <= '0;
      cksum_err <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_index <= '0;
          tx_shreg <= '0;
        end
        LOAD: begin
          tx_shreg <= tx_word;
          bit_cnt  <= '0;
          word_cnt <= '0;
          overrun  <= 1'b0;
          err_q    <= 1'b0;
`ifdef MYOCONTROL_SLAVE_CHECKSUM_EN
          tx_sum    <= tx_word;
          rx_sum    <= '0;
          cksum_err <= 1'b0;
`endif
        end
        SHIFT: begin
          // ss_n rise takes priority; a coincident sck edge is dropped.
          if (ss_rise) begin
`ifdef MYOCONTROL_SLAVE_CHECKSUM_EN
            err_q <= (bit_cnt != '0) | overrun | cksum_err;
`else
            err_q <= (bit_cnt != '0) | overrun;
`endif
          end else if (sck_rise) begin
            rx_shreg <= rx_next[DATA_WIDTH-2:0];
            if (bit_cnt == BIT_LAST) begin
              bit_cnt  <= '0;
              rx_word  <= rx_next;
              rx_index <= word_cnt;
              rx_valid <= (word_cnt < NWORDS);
              if (word_cnt >= NWORDS) overrun <= 1'b1;
              if (word_cnt != 8'hFF) word_cnt <= word_cnt + 8'd1;
              tx_index <= (word_cnt == 8'hFF) ? 8'hFF : word_cnt + 8'd1;
`ifdef MYOCONTROL_SLAVE_CHECKSUM_EN
              if (word_cnt < LAST_WORD)
                rx_sum <= rx_sum + rx_next;
              else if ((word_cnt == LAST_WORD) && (rx_next != rx_sum))
                cksum_err <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sck_fall) begin
            // bit_cnt wraps to 0 after a full word, so this fall starts the
            // next word; word_cnt already points at it.
            if (bit_cnt == '0) begin
              if (word_cnt >= NWORDS) begin
                tx_shreg <= '0;
`ifdef MYOCONTROL_SLAVE_CHECKSUM_EN
              end else if (word_cnt == LAST_WORD) begin
                tx_shreg <= tx_sum;
              end else begin
                tx_shreg <= tx_word;
                tx_sum   <= tx_sum + tx_word;
              end
`else
              end else begin
                tx_shreg <= tx_word;
              end
`endif
            end else begin
              tx_shreg <= {tx_shreg[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_myocontrol_spi_slave.sv
module tb_myocontrol_spi_slave;

  logic        clk = 1'b0;
  logic        reset, sck, mosi, ss_n;
  logic        miso, miso_oe;
  logic [7:0]  tx_index;
  logic [15:0] tx_word;
  logic [15:0] rx_word;
  logic [7:0]  rx_index;
  logic        rx_valid, frame_start, frame_done, frame_error;

  myocontrol_spi_slave #(.DATA_WIDTH(16), .FRAME_WORDS(12)) dut (
    .clk(clk), .reset(reset), .sck(sck), .mosi(mosi), .ss_n(ss_n),
    .miso(miso), .miso_oe(miso_oe), .tx_index(tx_index), .tx_word(tx_word),
    .rx_word(rx_word), .rx_index(rx_index), .rx_valid(rx_valid),
    .frame_start(frame_start), .frame_done(frame_done), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  // application side: one cycle registered lookup
  always @(posedge clk) tx_word <= 16'hA500 | {8'h00, tx_index};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0;
  int errs = 0;

  logic [15:0] mosi_words [32];
  logic [15:0] miso_cap [32];
  logic        fs_at3, miso_at3, miso_at4;
  int          t_rise16;

  logic [15:0] rx_w [32];
  logic [7:0]  rx_i [32];
  int          rx_n, fs_n, fd_n, rxv_cyc;
  logic        fe_last;

  always @(negedge clk) begin
    if (rx_valid && rx_n < 32) begin
      rx_w[rx_n] = rx_word;
      rx_i[rx_n] = rx_index;
      if (rx_n == 0) rxv_cyc = cyc;
      rx_n++;
    end
    if (frame_start) fs_n++;
    if (frame_done) begin
      fd_n++;
      fe_last = frame_error;
    end
  end

  task automatic clear_mon();
    rx_n = 0; fs_n = 0; fd_n = 0; rxv_cyc = -1; fe_last = 1'bx;
  endtask

  // Mode-0 master: nwords full words, then nbits_last bits of one more word.
  task automatic spi_frame(input int nwords, input int nbits_last, input bit raise_ss);
    int nw;
    int nb;
    logic [15:0] cap;
    ss_n = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 3) begin fs_at3 = frame_start; miso_at3 = miso; end
      if (i == 4) miso_at4 = miso;
    end
    nw = nwords + ((nbits_last > 0) ? 1 : 0);
    for (int w = 0; w < nw; w++) begin
      nb = (w < nwords) ? 16 : nbits_last;
      cap = '0;
      for (int b = 0; b < nb; b++) begin
        mosi = mosi_words[w][15-b];
        repeat (4) @(negedge clk);
        cap = {cap[14:0], miso};
        sck = 1'b1;
        if (w == 0 && b == 15) t_rise16 = cyc;
        repeat (4) @(negedge clk);
        sck = 1'b0;
      end
      if (w < nwords) miso_cap[w] = cap;
    end
    if (raise_ss) begin
      repeat (4) @(negedge clk);
      ss_n = 1'b1;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [44:0] obs;
    reset = 1'b1; ss_n = 1'b1; sck = 1'b0; mosi = 1'b0;
    repeat (5) @(negedge clk);
    obs = {miso, miso_oe, tx_index, rx_word, rx_index, rx_valid, frame_start, frame_done, frame_error};
    vecs++;
    if (obs !== '0) begin errs++; $display("FAIL reset_outputs got %h exp 0", obs); end
    reset = 1'b0;
    clear_mon();
    repeat (12) @(negedge clk);
    vecs++;
    if (fs_n !== 0 || fd_n !== 0) begin
      errs++; $display("FAIL idle_no_strobe got fs=%0d fd=%0d exp 0/0", fs_n, fd_n);
    end
    vecs++;
    if (tx_index !== 8'd0 || miso_oe !== 1'b0) begin
      errs++; $display("FAIL idle_outputs got tx_index=%0d oe=%b exp 0/0", tx_index, miso_oe);
    end
  endtask

  task automatic test_full_frame();
    logic [15:0] exp;
    logic [15:0] sum;
    logic        exp_fe;
    for (int i = 0; i < 12; i++) mosi_words[i] = 16'(i + 1);
    clear_mon();
    spi_frame(12, 0, 1'b1);
    vecs++;
    if (fs_n !== 1 || fs_at3 !== 1'b1) begin
      errs++; $display("FAIL full_frame_start got n=%0d at3=%b exp 1/1", fs_n, fs_at3);
    end
    vecs++;
    if (miso_at3 !== 1'b0 || miso_at4 !== 1'b1) begin
      errs++; $display("FAIL full_miso_msb_latency got at3=%b at4=%b exp 0/1", miso_at3, miso_at4);
    end
    vecs++;
    if (rxv_cyc - t_rise16 !== 3) begin
      errs++; $display("FAIL full_rx_valid_latency got %0d exp 3", rxv_cyc - t_rise16);
    end
    vecs++;
    if (rx_n !== 12) begin errs++; $display("FAIL full_rx_count got %0d exp 12", rx_n); end
    for (int i = 0; i < 12 && i < rx_n; i++) begin
      vecs++;
      if (rx_w[i] !== 16'(i + 1) || rx_i[i] !== 8'(i)) begin
        errs++; $display("FAIL full_rx[%0d] got %h@%0d exp %h@%0d", i, rx_w[i], rx_i[i], 16'(i + 1), i);
      end
    end
    sum = '0;
    for (int i = 0; i < 12; i++) begin
      exp = 16'hA500 | 16'(i);
`ifdef MYOCONTROL_SLAVE_CHECKSUM_EN
      if (i == 11) exp = sum;
`endif
      sum = sum + exp;
      vecs++;
      if (miso_cap[i] !== exp) begin
        errs++; $display("FAIL full_miso[%0d] got %h exp %h", i, miso_cap[i], exp);
      end
    end
`ifdef MYOCONTROL_SLAVE_CHECKSUM_EN
    exp_fe = 1'b1;  // received word 11 (0x000C) is not the sum of 1..11
`else
    exp_fe = 1'b0;
`endif
    vecs++;
    if (fd_n !== 1 || fe_last !== exp_fe) begin
      errs++; $display("FAIL full_done got n=%0d err=%b exp 1/%b", fd_n, fe_last, exp_fe);
    end
    vecs++;
    if (tx_index !== 8'd0 || miso_oe !== 1'b0) begin
      errs++; $display("FAIL full_back_to_idle got tx_index=%0d oe=%b exp 0/0", tx_index, miso_oe);
    end
  endtask

  task automatic test_partial();
    for (int i = 0; i < 4; i++) mosi_words[i] = 16'h1000 + 16'(i);
    clear_mon();
    spi_frame(3, 7, 1'b1);
    vecs++;
    if (rx_n !== 3) begin errs++; $display("FAIL partial_rx_count got %0d exp 3", rx_n); end
    for (int i = 0; i < 3 && i < rx_n; i++) begin
      vecs++;
      if (rx_w[i] !== 16'h1000 + 16'(i) || rx_i[i] !== 8'(i)) begin
        errs++; $display("FAIL partial_rx[%0d] got %h@%0d exp %h@%0d", i, rx_w[i], rx_i[i], 16'h1000 + 16'(i), i);
      end
    end
    vecs++;
    if (fd_n !== 1 || fe_last !== 1'b1) begin
      errs++; $display("FAIL partial_done got n=%0d err=%b exp 1/1", fd_n, fe_last);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 14; i++) mosi_words[i] = 16'h0F00 + 16'(i);
    clear_mon();
    spi_frame(14, 0, 1'b1);
    vecs++;
    if (rx_n !== 12) begin errs++; $display("FAIL overrun_rx_count got %0d exp 12", rx_n); end
    vecs++;
    if (rx_n > 11 && (rx_w[11] !== 16'h0F0B || rx_i[11] !== 8'd11)) begin
      errs++; $display("FAIL overrun_last_rx got %h@%0d exp 0f0b@11", rx_w[11], rx_i[11]);
    end
    for (int i = 12; i < 14; i++) begin
      vecs++;
      if (miso_cap[i] !== 16'h0000) begin
        errs++; $display("FAIL overrun_miso[%0d] got %h exp 0000", i, miso_cap[i]);
      end
    end
    vecs++;
    if (fd_n !== 1 || fe_last !== 1'b1) begin
      errs++; $display("FAIL overrun_done got n=%0d err=%b exp 1/1", fd_n, fe_last);
    end
  endtask

`ifdef MYOCONTROL_SLAVE_CHECKSUM_EN
  task automatic test_checksum();
    logic [15:0] sum;
    sum = '0;
    for (int i = 0; i < 11; i++) sum = sum + (16'hA500 | 16'(i));
    for (int i = 0; i < 12; i++) mosi_words[i] = 16'h8000;
    clear_mon();
    spi_frame(12, 0, 1'b1);
    vecs++;
    if (fd_n !== 1 || fe_last !== 1'b0) begin
      errs++; $display("FAIL cksum_good got n=%0d err=%b exp 1/0", fd_n, fe_last);
    end
    vecs++;
    if (miso_cap[11] !== sum) begin
      errs++; $display("FAIL cksum_tx got %h exp %h", miso_cap[11], sum);
    end
    mosi_words[11] = 16'h0000;
    clear_mon();
    spi_frame(12, 0, 1'b1);
    vecs++;
    if (fd_n !== 1 || fe_last !== 1'b1 || rx_n !== 12) begin
      errs++; $display("FAIL cksum_bad got n=%0d err=%b rx=%0d exp 1/1/12", fd_n, fe_last, rx_n);
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [44:0] obs;
    for (int i = 0; i < 6; i++) mosi_words[i] = 16'h2200 + 16'(i);
    clear_mon();
    spi_frame(5, 5, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    obs = {miso, miso_oe, tx_index, rx_word, rx_index, rx_valid, frame_start, frame_done, frame_error};
    vecs++;
    if (obs !== '0) begin errs++; $display("FAIL midreset_outputs got %h exp 0", obs); end
    ss_n = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    vecs++;
    if (fd_n !== 0 || fs_n !== 1) begin
      errs++; $display("FAIL midreset_strobes got fs=%0d fd=%0d exp 1/0", fs_n, fd_n);
    end
    mosi_words[0] = 16'h1234;
    mosi_words[1] = 16'h5678;
    clear_mon();
    spi_frame(2, 0, 1'b1);
    vecs++;
    if (rx_n !== 2 || rx_w[0] !== 16'h1234 || rx_i[0] !== 8'd0 || rx_w[1] !== 16'h5678 || rx_i[1] !== 8'd1) begin
      errs++; $display("FAIL after_reset_rx got n=%0d %h@%0d %h@%0d exp 2 1234@0 5678@1", rx_n, rx_w[0], rx_i[0], rx_w[1], rx_i[1]);
    end
    vecs++;
    if (miso_cap[0] !== 16'hA500 || miso_cap[1] !== 16'hA501) begin
      errs++; $display("FAIL after_reset_miso got %h %h exp a500 a501", miso_cap[0], miso_cap[1]);
    end
    vecs++;
    if (fd_n !== 1 || fe_last !== 1'b0) begin
      errs++; $display("FAIL after_reset_done got n=%0d err=%b exp 1/0", fd_n, fe_last);
    end
  endtask

  initial begin
    reset = 1'b1; ss_n = 1'b1; sck = 1'b0; mosi = 1'b0;
    clear_mon();
    test_reset();
    test_full_frame();
    test_partial();
    test_overrun();
`ifdef MYOCONTROL_SLAVE_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/myocontrol_spi_slave.md
# myocontrol_spi_slave

SPI slave endpoint that answers the myocontrol SPI master from the motor-board side of the link. It oversamples `sck`/`mosi`/`ss_n` in the local clock domain and deframes 16-bit words into a strobed receive stream. In the same frame it serialises a transmit word stream onto `miso`, fetched from application logic by word index. It replaces the per-board bridge logic between the myocontrol bus and the local motor-control register file.

## Interface
- `DATA_WIDTH`, 16: bits per SPI word, MSB first.
- `FRAME_WORDS`, 12: words per nominal frame; range 2..255.
- `clk` in 1: system clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `sck` in 1: SPI clock from master, asynchronous. Mode 0: CPOL=0, CPHA=0.
- `mosi` in 1: master data, asynchronous.
- `ss_n` in 1: slave select, active-low, asynchronous.
- `miso` out 1: slave data to master.
- `miso_oe` out 1: high while the frame is active; the pad is tri-stated otherwise.
- `tx_index` out 8: index of the next word to transmit.
- `tx_word` in DATA_WIDTH: application word for `tx_index`; registered lookup allowed.
- `rx_word` out DATA_WIDTH: last received word.
- `rx_index` out 8: index of `rx_word` within the frame.
- `rx_valid` out 1: one-cycle strobe, `rx_word`/`rx_index` valid.
- `frame_start` out 1: one-cycle strobe on synchronized `ss_n` fall.
- `frame_done` out 1: one-cycle strobe on synchronized `ss_n` rise.
- `frame_error` out 1: qualified by `frame_done`; set for partial word, overrun or checksum fail.

## Operation
- Input path:
  - `sck`, `mosi` and `ss_n` each pass through a 2-FF synchronizer, then one edge-detect register.
  - `ss_n` synchronizer flops reset to 1; `sck` flops reset to 0.
- FSM states:
  - IDLE: `ss_n` synced high. `tx_index`=0, `miso_oe`=0. On `ss_n` fall go to LOAD.
  - LOAD: one cycle. Shift register ← `tx_word`; `miso` = MSB. Pulse `frame_start`; clear bit and word counters. Go to SHIFT.
  - SHIFT, sck rise: shift in `mosi` and increment the bit counter.
  - SHIFT, on the 16th rise: `rx_word` ← assembled word, `rx_index` ← word counter, pulse `rx_valid` if word counter < FRAME_WORDS. Word counter +1; `tx_index` ← word counter+1.
  - SHIFT, sck fall: if bit counter = 0 (word boundary), load `tx_word`; otherwise shift out the next bit.
  - SHIFT: on `ss_n` rise go to DONE.
  - DONE: one cycle. Pulse `frame_done` with `frame_error` evaluated. Go to IDLE.
- Word index ≥ FRAME_WORDS (overrun):
  - no `rx_valid`;
  - `miso` shifts zeros;
  - word counter saturates at 255;
  - `frame_error` set at DONE.
- Error conditions: bit counter ≠ 0 at `ss_n` rise (partial word), or overrun, sets `frame_error`.
- Zero-word frames (select with no clocks) give `frame_done` with `frame_error`=0.
- `sck` edges seen while in IDLE are ignored.
- Reset values: `miso`=0, `miso_oe`=0, `tx_index`=0, `rx_word`=0, `rx_index`=0, `rx_valid`=0, `frame_start`=0, `frame_done`=0, `frame_error`=0, FSM=IDLE.
- Reset mid-frame: the frame is abandoned with no `frame_done`. The FSM re-enters LOAD only on the next synced `ss_n` fall.
- Simultaneous `ss_n` rise and `sck` edge in one cycle: `ss_n` wins; the edge is discarded.

## Timing
- Synced-edge latency is 3 clk after the pin edge.
- `rx_valid` pulses 3 clk after the 16th pin rising edge of `sck`.
- `frame_start` pulses 3 clk after the `ss_n` pin fall. `miso` MSB of word 0 is valid 4 clk after the `ss_n` pin fall.
- Master constraints:
  - `ss_n` fall to first `sck` rise ≥ 6 clk;
  - `sck` high and low times each ≥ 4 clk (fsck ≤ fclk/8);
  - last `sck` fall to `ss_n` rise ≥ 4 clk.
- `tx_index` updates ≥ 4 clk before the sck fall that loads `tx_word`. The application may use 1 cycle of registered read latency.
- `miso` changes 3 clk after the `sck` pin fall, which gives ≥1 clk setup before the next master sample.

## Configuration
- `MYOCONTROL_SLAVE_CHECKSUM_EN` defined:
  - Transmit word FRAME_WORDS−1 is replaced by the 16-bit wrap-around sum of transmitted words 0..FRAME_WORDS−2; `tx_word` is ignored for that index.
  - Received word FRAME_WORDS−1 is compared with the wrap sum of received words 0..FRAME_WORDS−2. On mismatch, `frame_error`=1 at DONE; `rx_valid` for that word still pulses.
- Macro undefined:
  - no summing logic;
  - every word is passed through;
  - `frame_error` covers only partial word and overrun.

## Test plan
- Reset, then idle with `ss_n`=1 → all outputs 0 and `tx_index`=0; after reset deassert, `frame_start` does not pulse until an `ss_n` fall.
- Full 12-word frame, fsck = fclk/8, mosi words 0x0001..0x000C, `tx_word` = 0xA500 | `tx_index` → 12 `rx_valid` with matching index/value; master captures 0xA500..0xA50B; `frame_error`=0.
- `ss_n` rises after 7 bits of word 3 → 3 `rx_valid` (indices 0..2), then `frame_done` with `frame_error`=1.
- 14-word frame → 12 `rx_valid`, words 12–13 read back as 0x0000 on `miso`, `frame_error`=1.
- Checksum macro defined, words 0..10 = 0x8000 each, word 11 = 0x8000 → no error (11×0x8000 mod 2^16 = 0x8000); word 11 = 0x0000 → `frame_error`=1. Transmitted word 11 equals the wrap sum of `tx_word` 0..10.
- `reset` asserted mid-word 5 → outputs return to reset values, no `frame_done`; the next frame starts cleanly at index 0.
